// File: rtl/shift_seq_pkg.sv
// Shared types and Am2904 code constants for the shift sequencer.
package shift_seq_pkg;

    localparam int unsigned IW  = 13;
    localparam int unsigned SCW = 5;
    localparam int unsigned CCW = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEST,
        ST_SHIFT,
        ST_STATUS,
        ST_DONE
    } state_e;

    // Am2904 I[10:6] shift-linkage codes
    localparam logic [SCW-1:0] SH_DN_0        = 5'o00;
    localparam logic [SCW-1:0] SH_DN_DBL_SIO0 = 5'o06;
    localparam logic [SCW-1:0] SH_UP_0        = 5'o22;
    localparam logic [SCW-1:0] SH_UP_DBL_0    = 5'o26;

    // Am2904 I[5:0] condition codes
    localparam logic [CCW-1:0] CC_UZ         = 6'h04;
    localparam logic [CCW-1:0] CC_UN         = 6'h1e;
    localparam logic [CCW-1:0] CC_MN_NE_MOVR = 6'h22;

    // Am2904 I[5:0] status-load codes
    localparam logic [CCW-1:0] SL_NOP          = 6'o00;
    localparam logic [CCW-1:0] SL_MSR_DIR_USR_OVR = 6'o07;

    typedef struct packed {
        logic [1:0]     cin_sel;
        logic [SCW-1:0] shift_code;
        logic           norm;
        logic [CCW-1:0] test_code;
        logic           update_msr;
        logic           update_usr;
    } cmd_t;

endpackage

// File: rtl/shift_sequencer.sv
// Multi-cycle Am2904/Am2901 shift controller: optional CT-normalize loop,
// step counting and an optional final status-load cycle.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned    CW          = 6,
    parameter logic [CCW-1:0] STATUS_CODE = 6'o07,
    parameter logic [CCW-1:0] IDLE_CODE   = 6'o00
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           ready,
    input  logic [SCW-1:0] shift_code,
    input  logic [1:0]     cin_sel,
    input  logic [CW-1:0]  count,
    input  logic           norm,
    input  logic [CCW-1:0] test_code,
    input  logic           update_msr,
    input  logic           update_usr,
    input  logic           ct,
    output logic [IW-1:0]  I,
    output logic           nSE,
    output logic           nCEm,
    output logic           nCEu,
    output logic           nOEct,
    output logic           slice_shift,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  steps,
    output logic           hit
);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   steps_q, steps_d;
    logic            hit_q, hit_d;

    logic [IW-1:0]   i_q, i_d;
    logic            nse_q, nse_d;
    logic            ncem_q, ncem_d;
    logic            nceu_q, nceu_d;
    logic            noect_q, noect_d;
    logic            slice_q, slice_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            cmd_has_status;
    logic            in_has_status;

    assign cmd_has_status = cmd_q.update_msr | cmd_q.update_usr;
    assign in_has_status  = update_msr | update_usr;

    // Next state, command latch and step counter
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        count_d = count_q;
        steps_d = steps_q;
        hit_d   = hit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_d   = '{cin_sel: cin_sel, shift_code: shift_code, norm: norm,
                                test_code: test_code, update_msr: update_msr,
                                update_usr: update_usr};
                    count_d = count;
                    steps_d = '0;
                    hit_d   = 1'b0;
                    if (count == '0)
                        state_d = in_has_status ? ST_STATUS : ST_DONE;
                    else
                        state_d = norm ? ST_TEST : ST_SHIFT;
                end
            end
            ST_TEST: begin
                if (ct) begin
                    hit_d   = 1'b1;
                    state_d = cmd_has_status ? ST_STATUS : ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                steps_d = steps_q + CW'(1);
                if (steps_d == count_q)
                    state_d = cmd_has_status ? ST_STATUS : ST_DONE;
                else
                    state_d = cmd_q.norm ? ST_TEST : ST_SHIFT;
            end
            ST_STATUS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        i_d     = {2'b00, SCW'(0), IDLE_CODE};
        nse_d   = 1'b1;
        ncem_d  = 1'b1;
        nceu_d  = 1'b1;
        noect_d = 1'b1;
        slice_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_d != ST_IDLE) begin
            i_d[12:11] = cmd_d.cin_sel;
            i_d[10:6]  = cmd_d.shift_code;
            busy_d     = 1'b1;
        end
        unique case (state_d)
            ST_TEST: begin
                noect_d   = 1'b0;
                i_d[5:0]  = cmd_d.test_code;
            end
            ST_SHIFT: begin
                nse_d   = 1'b0;
                slice_d = 1'b1;
            end
            ST_STATUS: begin
                i_d[5:0] = STATUS_CODE;
                ncem_d   = ~cmd_d.update_msr;
                nceu_d   = ~cmd_d.update_usr;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            count_q <= '0;
            steps_q <= '0;
            hit_q   <= 1'b0;
            i_q     <= {2'b00, SCW'(0), IDLE_CODE};
            nse_q   <= 1'b1;
            ncem_q  <= 1'b1;
            nceu_q  <= 1'b1;
            noect_q <= 1'b1;
            slice_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            count_q <= count_d;
            steps_q <= steps_d;
            hit_q   <= hit_d;
            i_q     <= i_d;
            nse_q   <= nse_d;
            ncem_q  <= ncem_d;
            nceu_q  <= nceu_d;
            noect_q <= noect_d;
            slice_q <= slice_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign I           = i_q;
    assign nSE         = nse_q;
    assign nCEm        = ncem_q;
    assign nCEu        = nceu_q;
    assign nOEct       = noect_q;
    assign slice_shift = slice_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign steps       = steps_q;
    assign hit         = hit_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed cycle expectations.
module tb_shift_sequencer;

    localparam int unsigned CW = 6;

    logic          clk;
    logic          reset;
    logic          start;
    logic          ready;
    logic [4:0]    shift_code;
    logic [1:0]    cin_sel;
    logic [CW-1:0] count;
    logic          norm;
    logic [5:0]    test_code;
    logic          update_msr;
    logic          update_usr;
    logic          ct;
    logic [12:0]   I;
    logic          nSE, nCEm, nCEu, nOEct, slice_shift, busy, done, hit;
    logic [CW-1:0] steps;

    int n_run;
    int n_fail;

    shift_sequencer #(.CW(CW), .STATUS_CODE(6'o07), .IDLE_CODE(6'o00)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .shift_code(shift_code), .cin_sel(cin_sel), .count(count), .norm(norm),
        .test_code(test_code), .update_msr(update_msr), .update_usr(update_usr),
        .ct(ct), .I(I), .nSE(nSE), .nCEm(nCEm), .nCEu(nCEu), .nOEct(nOEct),
        .slice_shift(slice_shift), .busy(busy), .done(done), .steps(steps), .hit(hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [CW-1:0] cnt, input logic [4:0] sc, input logic [1:0] cs,
                         input logic nm, input logic [5:0] tc, input logic um, input logic uu);
        count      = cnt;
        shift_code = sc;
        cin_sel    = cs;
        norm       = nm;
        test_code  = tc;
        update_msr = um;
        update_usr = uu;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_I"},     32'(I), 32'h0000);
        check({tag, "_nSE"},   32'(nSE), 32'd1);
        check({tag, "_nCEm"},  32'(nCEm), 32'd1);
        check({tag, "_nCEu"},  32'(nCEu), 32'd1);
        check({tag, "_nOEct"}, 32'(nOEct), 32'd1);
        check({tag, "_slice"}, 32'(slice_shift), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [1:0] cin_seq [4];
        n_run = 0;
        n_fail = 0;
        reset = 1'b1; start = 1'b0; ct = 1'b0;
        shift_code = '0; cin_sel = '0; count = '0; norm = 1'b0;
        test_code = '0; update_msr = 1'b0; update_usr = 1'b0;
        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_steps", 32'(steps), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        reset = 1'b0;
        tick();

        // plain shift, count=3
        issue(6'd3, 5'o22, 2'b01, 1'b0, 6'h00, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            check("p3_nSE", 32'(nSE), 32'd0);
            check("p3_slice", 32'(slice_shift), 32'd1);
            check("p3_I", 32'(I), 32'({2'b01, 5'o22, 6'o00}));
            check("p3_nCE", 32'({nCEm, nCEu}), 32'd3);
            check("p3_busy_ready", 32'({busy, ready}), 32'b10);
            tick();
        end
        check("p3_done", 32'(done), 32'd1);
        check("p3_done_nSE", 32'(nSE), 32'd1);
        check("p3_steps", 32'(steps), 32'd3);
        tick();
        check("p3_after_done", 32'(done), 32'd0);
        check("p3_after_ready", 32'(ready), 32'd1);

        // count=0 with MSR load only
        issue(6'd0, 5'o06, 2'b10, 1'b0, 6'h00, 1'b1, 1'b0);
        check("s0_I", 32'(I), 32'({2'b10, 5'o06, 6'o07}));
        check("s0_nCE", 32'({nCEm, nCEu}), 32'b01);
        check("s0_slice", 32'(slice_shift), 32'd0);
        check("s0_busy", 32'(busy), 32'd1);
        tick();
        check("s0_done", 32'(done), 32'd1);
        check("s0_steps", 32'(steps), 32'd0);
        check("s0_done_nCE", 32'({nCEm, nCEu}), 32'b11);
        tick();

        // normalize, CT rises after second shift; ct=1 in a SHIFT cycle is ignored
        issue(6'd8, 5'o26, 2'b11, 1'b1, 6'h22, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            logic [4:0] exp_p;
            // expected {nOEct, nSE, slice, done, busy} per cycle
            case (c)
                1, 3, 5: exp_p = 5'b01001;
                2, 4:    exp_p = 5'b10101;
                default: exp_p = 5'b11011;
            endcase
            check($sformatf("n8_c%0d", c), 32'({nOEct, nSE, slice_shift, done, busy}), 32'(exp_p));
            if (c == 1 || c == 3 || c == 5)
                check($sformatf("n8_I_c%0d", c), 32'(I), 32'({2'b11, 5'o26, 6'h22}));
            ct = (c == 2 || c == 5);
            tick();
            ct = 1'b0;
            if (c == 6) break;
        end
        check("n8_hit", 32'(hit), 32'd1);
        check("n8_steps", 32'(steps), 32'd2);
        tick();

        // normalize, CT never true, uSR load
        issue(6'd4, 5'o00, 2'b01, 1'b1, 6'h1e, 1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8) begin
                check($sformatf("n4_c%0d_nOEct", c), 32'(nOEct), 32'(c % 2 == 0));
                check($sformatf("n4_c%0d_slice", c), 32'(slice_shift), 32'(c % 2 == 0));
            end else if (c == 9) begin
                check("n4_stat_I", 32'(I[5:0]), 32'h07);
                check("n4_stat_nCE", 32'({nCEm, nCEu}), 32'b10);
                check("n4_stat_done", 32'(done), 32'd0);
            end else begin
                check("n4_done", 32'(done), 32'd1);
            end
            tick();
        end
        check("n4_hit", 32'(hit), 32'd0);
        check("n4_steps", 32'(steps), 32'd4);
        check("n4_ready", 32'(ready), 32'd1);

        // start while busy is ignored
        issue(6'd5, 5'o22, 2'b00, 1'b0, 6'h00, 1'b0, 1'b0);
        tick();
        count = 6'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_ready", 32'(ready), 32'd0);
        check("ign_slice", 32'(slice_shift), 32'd1);
        tick();
        tick();
        tick();
        check("ign_done", 32'(done), 32'd1);
        check("ign_steps", 32'(steps), 32'd5);
        tick();

        // reset mid-SHIFT
        issue(6'd5, 5'o22, 2'b10, 1'b0, 6'h00, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("mrst");
        check("mrst_steps", 32'(steps), 32'd0);
        check("mrst_hit", 32'(hit), 32'd0);
        tick();
        check("mrst_hold_ready", 32'(ready), 32'd1);

        // start held high, count=1: one command every 3 cycles
        cin_seq[0] = 2'b10; cin_seq[1] = 2'b11; cin_seq[2] = 2'b01; cin_seq[3] = 2'b00;
        count = 6'd1; shift_code = 5'o22; norm = 1'b0; update_msr = 1'b0; update_usr = 1'b0;
        cin_sel = cin_seq[0];
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d_slice", k), 32'(slice_shift), 32'd1);
            check($sformatf("hold%0d_cin", k), 32'(I[12:11]), 32'(cin_seq[k]));
            cin_sel = cin_seq[k + 1];
            tick();
            check($sformatf("hold%0d_done", k), 32'(done), 32'd1);
            tick();
            check($sformatf("hold%0d_ready", k), 32'({ready, busy}), 32'b10);
            tick();
        end
        start = 1'b0;
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
